// File: rtl/sw_evt_pkg.sv
`default_nettype none
// ============================================================================
// Package : sw_evt_pkg
// Purpose : Shared definitions for the switch event generator: event kind
//           codes, per-channel FSM state encoding, pend-bit positions and a
//           counter-width helper.
// Revision: 1.0  initial release
// ============================================================================
package sw_evt_pkg;

    // Event kind codes driven on evt_kind
    localparam logic [1:0] KIND_PRESS   = 2'd0;
    localparam logic [1:0] KIND_REPEAT  = 2'd1;
    localparam logic [1:0] KIND_RELEASE = 2'd2;

    // Bit positions inside a channel's 3-bit pend/clear vectors
    localparam int PEND_PRESS = 0;
    localparam int PEND_REP   = 1;
    localparam int PEND_REL   = 2;

    // Per-channel FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } chan_state_t;

    // Countdown width: enough bits to hold the larger reload value
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_event_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : sw_event_gen_if
// Purpose   : Valid/ready event port between the switch event generator
//             (master) and its consumer (slave).
// Signals   : evt_valid  event present on evt_chan/evt_kind
//             evt_ready  consumer accepts when evt_valid & evt_ready
//             evt_chan   channel index of the event
//             evt_kind   00 PRESS, 01 REPEAT, 10 RELEASE
// Revision  : 1.0  initial release
// ============================================================================
interface sw_event_gen_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_chan;
    logic [1:0] evt_kind;

    modport master (output evt_valid, output evt_chan, output evt_kind, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_chan, input  evt_kind, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/sw_event_chan.sv
`default_nettype none
// ============================================================================
// Module  : sw_event_chan
// Purpose : One switch channel: rising-edge detection against a registered
//           history, IDLE/HOLD/RPT FSM with hold/repeat countdown, and sticky
//           pend_press/pend_rep/pend_rel flags cleared by the arbiter.
// Ports   : clk, reset   clock, synchronous active-high reset
//           sw_i         debounced switch level
//           clr_i[2:0]   clear request for pend bits (press/rep/rel)
//           pend_o[2:0]  pending events (press/rep/rel)
// Revision: 1.0  initial release
// ============================================================================
module sw_event_chan
    import sw_evt_pkg::*;
#(
    parameter int HOLD_CYCLES   = 12_500_000,
    parameter int REPEAT_CYCLES = 2_500_000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       sw_i,
    input  wire logic [2:0] clr_i,
    output logic      [2:0] pend_o
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LOAD  = CNT_W'(REPEAT_CYCLES - 1);

    chan_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sw_q;
    logic [2:0]       pend_q;

    // Later assignments to individual pend bits override the default clear,
    // so a set and a clear landing on the same edge resolve to set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sw_q    <= 1'b0;
            pend_q  <= 3'b000;
        end else begin
            sw_q   <= sw_i;
            pend_q <= pend_q & ~clr_i;
            case (state_q)
                ST_IDLE: begin
                    if (sw_i && !sw_q) begin
                        pend_q[PEND_PRESS] <= 1'b1;
                        cnt_q              <= HOLD_LOAD;
                        state_q            <= ST_HOLD;
                    end
                end
                ST_HOLD, ST_RPT: begin
                    // Release wins over a countdown expiry in the same cycle
                    if (!sw_i) begin
                        pend_q[PEND_REL] <= 1'b1;
                        pend_q[PEND_REP] <= 1'b0;
                        state_q          <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        // Already-pending repeat simply stays set (coalesced)
                        pend_q[PEND_REP] <= 1'b1;
                        cnt_q            <= RPT_LOAD;
                        state_q          <= ST_RPT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pend_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/sw_event_gen.sv
`default_nettype none
// ============================================================================
// Module  : sw_event_gen
// Purpose : Turns debounced switch levels into PRESS/REPEAT/RELEASE events,
//           one at a time on a valid/ready port. Fixed-priority arbiter
//           (lowest channel, then PRESS > REPEAT > RELEASE) feeding a
//           single-entry output register.
// Ports   : clk, reset      clock, synchronous active-high reset
//           sw_db_i[N_SW]   debounced switch levels (synchronous to clk)
//           evt             event port (master side of sw_event_gen_if)
// Revision: 1.0  initial release
// ============================================================================
module sw_event_gen
    import sw_evt_pkg::*;
#(
    parameter int N_SW          = 3,
    parameter int HOLD_CYCLES   = 12_500_000,
    parameter int REPEAT_CYCLES = 2_500_000
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [N_SW-1:0] sw_db_i,
    sw_event_gen_if.master       evt
);

    if (N_SW < 1 || N_SW > 4) begin : g_nsw_check
        $error("sw_event_gen: N_SW must be 1..4");
    end
    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_cycles_check
        $error("sw_event_gen: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic [N_SW-1:0][2:0] pend;
    logic [N_SW-1:0][2:0] clr;

    for (genvar g = 0; g < N_SW; g++) begin : g_chan
        sw_event_chan #(
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .sw_i   (sw_db_i[g]),
            .clr_i  (clr[g]),
            .pend_o (pend[g])
        );
    end

    logic       valid_q, valid_d;
    logic [1:0] chan_q,  chan_d;
    logic [1:0] kind_q,  kind_d;
    logic       load_en;
    logic       found;
    logic [1:0] sel_chan;
    logic [1:0] sel_kind;

    // Register may take a new event when empty or draining this cycle
    assign load_en = !valid_q || evt.evt_ready;

    always_comb begin
        found    = 1'b0;
        sel_chan = 2'd0;
        sel_kind = KIND_PRESS;
        clr      = '0;
        for (int c = 0; c < N_SW; c++) begin
            if (!found && (pend[c] != 3'b000)) begin
                found    = 1'b1;
                sel_chan = 2'(c);
                if (pend[c][PEND_PRESS]) begin
                    sel_kind = KIND_PRESS;
                    clr[c][PEND_PRESS] = load_en;
                end else if (pend[c][PEND_REP]) begin
                    sel_kind = KIND_REPEAT;
                    clr[c][PEND_REP] = load_en;
                end else begin
                    sel_kind = KIND_RELEASE;
                    clr[c][PEND_REL] = load_en;
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        chan_d  = chan_q;
        kind_d  = kind_q;
        if (load_en) begin
            valid_d = found;
            if (found) begin
                chan_d = sel_chan;
                kind_d = sel_kind;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            chan_q  <= 2'd0;
            kind_q  <= 2'd0;
        end else begin
            valid_q <= valid_d;
            chan_q  <= chan_d;
            kind_q  <= kind_d;
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_chan  = chan_q;
    assign evt.evt_kind  = kind_q;

endmodule
`default_nettype wire
